// File: rtl/serial_rx_if.sv
// Serial receiver bus: serial-side inputs plus the parallel word outputs.
interface serial_rx_if #(
    parameter int unsigned WIDTH = 32
);
    logic             sclk;
    logic             data_enable;
    logic             sdi;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output sclk, data_enable, sdi,
        input  data_out, data_valid, frame_err, busy
    );

    modport slave (
        input  sclk, data_enable, sdi,
        output data_out, data_valid, frame_err, busy
    );
endinterface

// File: rtl/serial_rx.sv
// MSB-first serial receiver: synchronizes sclk/data_enable/sdi into clk and rebuilds words.
// Optional feature: define SERIAL_RX_FRAME_CHECK_EN to complete at frame close and flag bad lengths.
module serial_rx #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    serial_rx_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 2);

    typedef enum logic {IDLE, RECV} state_t;

    logic [SYNC_STAGES-1:0] sclk_sq, en_sq, sdi_sq;
    logic                   sclk_hist, en_hist;
    logic [SYNC_STAGES:0]   warm;
    logic                   edges_ok, sclk_sync, en_sync, sdi_sync;
    logic                   sclk_re, en_re, en_fe;

    state_t                 state, state_d;
    logic [WIDTH-1:0]       shift_reg, shift_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [WIDTH-1:0]       data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   busy_q, busy_d;
`ifdef SERIAL_RX_FRAME_CHECK_EN
    logic                   frame_err_q, frame_err_d;
`endif

    // Synchronizers, one-flop history, and a warm-up window so a level already
    // high at reset release is never mistaken for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sq   <= '0;
            en_sq     <= '0;
            sdi_sq    <= '0;
            sclk_hist <= 1'b0;
            en_hist   <= 1'b0;
            warm      <= '0;
        end else begin
            sclk_sq   <= {sclk_sq[SYNC_STAGES-2:0], bus.sclk};
            en_sq     <= {en_sq[SYNC_STAGES-2:0], bus.data_enable};
            sdi_sq    <= {sdi_sq[SYNC_STAGES-2:0], bus.sdi};
            sclk_hist <= sclk_sq[SYNC_STAGES-1];
            en_hist   <= en_sq[SYNC_STAGES-1];
            warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign edges_ok  = warm[SYNC_STAGES];
    assign sclk_sync = sclk_sq[SYNC_STAGES-1];
    assign en_sync   = en_sq[SYNC_STAGES-1];
    assign sdi_sync  = sdi_sq[SYNC_STAGES-1];
    assign sclk_re   = edges_ok &  sclk_sync & ~sclk_hist;
    assign en_re     = edges_ok &  en_sync   & ~en_hist;
    assign en_fe     = edges_ok & ~en_sync   &  en_hist;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            cnt          <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SERIAL_RX_FRAME_CHECK_EN
            frame_err_q  <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            shift_reg    <= shift_d;
            cnt          <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
`ifdef SERIAL_RX_FRAME_CHECK_EN
            frame_err_q  <= frame_err_d;
`endif
        end
    end

    // Next state; frame close takes priority over a coincident sclk edge
    always_comb begin
        state_d      = state;
        shift_d      = shift_reg;
        cnt_d        = cnt;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
`ifdef SERIAL_RX_FRAME_CHECK_EN
        frame_err_d  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (en_re) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (en_fe) begin
                    state_d = IDLE;
`ifdef SERIAL_RX_FRAME_CHECK_EN
                    if (cnt == CNT_W'(WIDTH)) begin
                        data_out_d   = shift_reg;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
`endif
                end else if (sclk_re) begin
`ifdef SERIAL_RX_FRAME_CHECK_EN
                    shift_d = {shift_reg[WIDTH-2:0], sdi_sync};
                    if (cnt < CNT_W'(WIDTH + 1))
                        cnt_d = cnt + CNT_W'(1);
`else
                    // Bits beyond a full word are dropped until the frame closes
                    if (cnt < CNT_W'(WIDTH)) begin
                        shift_d = {shift_reg[WIDTH-2:0], sdi_sync};
                        cnt_d   = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            data_out_d   = shift_d;
                            data_valid_d = 1'b1;
                        end
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RECV);
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy_q;
`ifdef SERIAL_RX_FRAME_CHECK_EN
    assign bus.frame_err  = frame_err_q;
`else
    assign bus.frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: drives MSB-first frames and checks words, pulses and busy.
module tb_serial_rx;
    localparam int unsigned WIDTH = 32;
    localparam int          PH    = 6;   // clk cycles per sclk phase / setup / hold

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_rx_if #(.WIDTH(WIDTH)) ifc ();

    serial_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int checks = 0;
    int errors = 0;

    // Pulse monitor: counts high cycles of each pulse and logs delivered words
    int          vcnt = 0;
    int          ecnt = 0;
    int          dout_bad = 0;
    logic [31:0] vals [16];
    logic [31:0] prev_dout = '0;

    always @(posedge clk) begin
        if (ifc.data_valid) begin
            if (vcnt < 16) vals[vcnt] <= ifc.data_out;
            vcnt <= vcnt + 1;
        end
        if (ifc.frame_err) ecnt <= ecnt + 1;
        if (!rst && (ifc.data_out !== prev_dout) && !ifc.data_valid)
            dout_bad <= dout_bad + 1;
        prev_dout <= ifc.data_out;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send n bits of v MSB-first inside one enable window, then leave gap cycles low
    task automatic send_frame(input logic [63:0] v, input int n, input int gap, input string tag);
        ifc.data_enable = 1'b1;
        cyc(PH);
        for (int i = n - 1; i >= 0; i--) begin
            ifc.sdi = v[i];
            cyc(PH);
            ifc.sclk = 1'b1;
            cyc(PH);
            ifc.sclk = 1'b0;
            if (i == n / 2) check({tag, "_busy_mid"}, 64'(ifc.busy), 64'd1);
        end
        cyc(PH);
        ifc.data_enable = 1'b0;
        cyc(gap);
    endtask

    int exp_v = 0;
    int exp_e = 0;
    int busy_hi;

    initial begin
        ifc.sclk = 1'b0;
        ifc.data_enable = 1'b0;
        ifc.sdi = 1'b0;
        cyc(4);
        check("rst_data_out",   64'(ifc.data_out),   64'd0);
        check("rst_data_valid", 64'(ifc.data_valid), 64'd0);
        check("rst_frame_err",  64'(ifc.frame_err),  64'd0);
        check("rst_busy",       64'(ifc.busy),       64'd0);
        rst = 1'b0;
        cyc(6);

        // Single full frame
        send_frame(64'h0000_0000_A5C3_0F81, 32, 10, "f1");
        exp_v = 1;
        check("f1_valid_cnt", 64'(vcnt), 64'(exp_v));
        check("f1_word",      64'(vals[0]), 64'h0000_0000_A5C3_0F81);
        check("f1_data_out",  64'(ifc.data_out), 64'h0000_0000_A5C3_0F81);
        check("f1_err_cnt",   64'(ecnt), 64'd0);
        check("f1_busy_after", 64'(ifc.busy), 64'd0);

        // Back-to-back frames with minimum enable gap
        send_frame(64'h0000_0000_0000_0001, 32, 4, "b1");
        send_frame(64'h0000_0000_FFFF_FFFE, 32, 10, "b2");
        exp_v = 3;
        check("b2b_valid_cnt", 64'(vcnt), 64'(exp_v));
        check("b2b_word0",     64'(vals[1]), 64'h0000_0000_0000_0001);
        check("b2b_word1",     64'(vals[2]), 64'h0000_0000_FFFF_FFFE);

        // Short frame (31 bits)
        send_frame(64'h0000_0000_7FFF_FFFF, 31, 10, "s31");
`ifdef SERIAL_RX_FRAME_CHECK_EN
        exp_e = 1;
`endif
        check("short_valid_cnt", 64'(vcnt), 64'(exp_v));
        check("short_err_cnt",   64'(ecnt), 64'(exp_e));
        check("short_data_out",  64'(ifc.data_out), 64'h0000_0000_FFFF_FFFE);

        // Long frame (33 bits): 0x12345678 then an extra 1
        send_frame(64'h0000_0000_2468_ACF1, 33, 10, "l33");
`ifdef SERIAL_RX_FRAME_CHECK_EN
        exp_e = 2;
        check("long_data_out", 64'(ifc.data_out), 64'h0000_0000_FFFF_FFFE);
`else
        exp_v = 4;
        check("long_word",     64'(vals[3]), 64'h0000_0000_1234_5678);
        check("long_data_out", 64'(ifc.data_out), 64'h0000_0000_1234_5678);
`endif
        check("long_valid_cnt", 64'(vcnt), 64'(exp_v));
        check("long_err_cnt",   64'(ecnt), 64'(exp_e));

        // Reset mid-frame after 16 bits of 0xDEADBEEF, released with enable still high
        ifc.data_enable = 1'b1;
        cyc(PH);
        for (int i = 31; i >= 16; i--) begin
            logic [31:0] w;
            w = 32'hDEAD_BEEF;
            ifc.sdi = w[i];
            cyc(PH);
            ifc.sclk = 1'b1;
            cyc(PH);
            ifc.sclk = 1'b0;
        end
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(12);
        check("rstmid_busy",     64'(ifc.busy), 64'd0);
        check("rstmid_data_out", 64'(ifc.data_out), 64'd0);
        ifc.data_enable = 1'b0;
        cyc(10);
        check("rstmid_valid_cnt", 64'(vcnt), 64'(exp_v));
        check("rstmid_err_cnt",   64'(ecnt), 64'(exp_e));
        check("rstmid_busy_after", 64'(ifc.busy), 64'd0);

        send_frame(64'h0000_0000_CAFE_F00D, 32, 10, "post");
        exp_v = exp_v + 1;
        check("post_valid_cnt", 64'(vcnt), 64'(exp_v));
        check("post_word",      64'(vals[exp_v-1]), 64'h0000_0000_CAFE_F00D);
        check("post_data_out",  64'(ifc.data_out), 64'h0000_0000_CAFE_F00D);

        // sclk activity with enable low must do nothing
        busy_hi = 0;
        ifc.sdi = 1'b1;
        for (int p = 0; p < 5; p++) begin
            ifc.sclk = 1'b1;
            repeat (PH) begin
                @(negedge clk);
                if (ifc.busy) busy_hi++;
            end
            ifc.sclk = 1'b0;
            repeat (PH) begin
                @(negedge clk);
                if (ifc.busy) busy_hi++;
            end
        end
        cyc(6);
        check("idle_busy_cycles", 64'(busy_hi), 64'd0);
        check("idle_valid_cnt",   64'(vcnt), 64'(exp_v));
        check("idle_err_cnt",     64'(ecnt), 64'(exp_e));
        check("idle_data_out",    64'(ifc.data_out), 64'h0000_0000_CAFE_F00D);
        check("dout_stable_outside_valid", 64'(dout_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_rx.md
# serial_rx

Serial receiver that sits downstream of the team's serial transmitter and reassembles its MSB-first bit stream into parallel words. It samples the externally supplied serial clock, frame enable and data lines in the `clk` domain through synchronizers. It shifts in one bit per sclk rising edge while the frame is open, and presents a completed word with a one-cycle `data_valid` pulse. It also detects malformed frames.

## Interface
- `WIDTH`, 32: bits per frame / word width.
- `SYNC_STAGES`, 2: flip-flop stages on each asynchronous input (minimum 2).
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `sclk`  input  1  serial clock, asynchronous to `clk`.
- `data_enable`  input  1  frame enable / chip select, asynchronous; high while a frame is in progress.
- `sdi`  input  1  serial data in; changes on sclk falling edge, MSB first.
- `data_out`  output  WIDTH  last correctly received word; holds between frames.
- `data_valid`  output  1  one-cycle pulse when `data_out` updates.
- `frame_err`  output  1  one-cycle pulse on a malformed frame; only exists with the macro enabled, tied 0 otherwise.
- `busy`  output  1  high while in RECV.

## Operation
- `sclk`, `data_enable` and `sdi` each pass through a `SYNC_STAGES` synchronizer. Edge detection then uses a one-flop history of each synchronized signal. The edge flags are: `sclk_re`, `en_re` and `en_fe`.
- Internal state: `shift_reg[WIDTH-1:0]`; bit counter `cnt`, width clog2(WIDTH+2), saturating at WIDTH+1; `state` ∈ {IDLE, RECV}.
- IDLE:
  - `en_re` → clear `shift_reg` and `cnt`, go to RECV.
  - `sclk_re` is ignored.
- RECV:
  - Priority order is `en_fe`, then `sclk_re`. On `sclk_re` without `en_fe`: `shift_reg <= {shift_reg[WIDTH-2:0], sdi_sync}`, and `cnt` increments while it is below WIDTH+1.
  - `en_fe` → return to IDLE. The word completes as described under Configuration.
- Reset values: `data_out`=0, `data_valid`=0, `frame_err`=0, `busy`=0, state IDLE, `shift_reg`=0, `cnt`=0. All synchronizer and history flops reset to 0.
- Reset mid-frame discards the partial word. If `data_enable` is already high at reset release, it is not treated as a frame start. Reception waits for a fresh low→high transition.
- `data_out` changes only in the cycle `data_valid` is driven high.

## Timing
- Input to edge flag latency: SYNC_STAGES+1 `clk` cycles.
- `data_valid` / `frame_err` rise in the cycle after the edge flag that completes or closes the frame. Each is high for exactly one cycle.
- `busy` rises one cycle after `en_re` and falls one cycle after `en_fe`.
- Each sclk high and low phase, and the `data_enable` setup before the first sclk rise, must last at least SYNC_STAGES+2 `clk` cycles. Faster input is out of spec.
- `sdi` must be stable around the sclk rising edge. Because of equal synchronizer depth, `sdi_sync` is the value aligned to `sclk_re`.
- `sclk_re` coincident with `en_re`: ignored (not a data bit). `sclk_re` coincident with `en_fe`: ignored.
- Back-to-back frames: an `en_re` one cycle after `en_fe` is accepted.

## Configuration
- Macro `SERIAL_RX_FRAME_CHECK_EN`.
- Defined:
  - The word completes only at `en_fe`.
  - If `cnt`==WIDTH: `data_out <= shift_reg` and `data_valid` pulses.
  - Otherwise (short, or long via saturation at WIDTH+1): `frame_err` pulses and `data_out` is unchanged.
- Undefined:
  - The word completes on the `sclk_re` that makes `cnt`==WIDTH. In the next cycle, `data_out <=` the completed word and `data_valid` pulses.
  - Further sclk edges in the same frame are ignored.
  - `en_fe` only returns to IDLE. A short frame is silently dropped.
  - `frame_err` is constant 0.

## Test plan
- Reset, then frame 0xA5C3_0F81 with 32 sclk pulses → one `data_valid` pulse, `data_out`=0xA5C30F81, `frame_err`=0; `busy` high only during the frame.
- Frame 0x0000_0001 followed immediately by frame 0xFFFF_FFFE, with the minimum enable gap → two `data_valid` pulses with the respective values in order.
- 31-bit frame of 0x7FFF_FFFF → with the macro: `frame_err` pulse and `data_out` unchanged; without: no pulses at all.
- 33 sclk pulses, MSB-first payload 0x1234_5678 then an extra 1 → with the macro: `frame_err`; without: `data_valid` with 0x12345678 after bit 32 and the extra bit ignored.
- Assert `rst` after 16 bits of 0xDEAD_BEEF, then release with `data_enable` still high → no output pulses and `data_out`=0. The next full frame 0xCAFE_F00D is received correctly.
- sclk pulses with `data_enable` low → no state change, `busy`=0, no pulses.
